hps_sync_fifo: RTL
==================

HPS_SYNC_FIFO -- requirements
Module: hps_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: entry count; power of 2, at least 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full level; range 1..DEPTH.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty level; range 0..DEPTH-1.
REQ-005 SHALL have the following ports; AW = log2(DEPTH):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  write request.
- data_in  in  DATA_W  write data.
- rd_en  in  1  read request.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  data_out updated this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  clears overflow and underflow.

Function
REQ-006 SHALL accept a write iff wr_en=1 and full=0: store data_in at wr_ptr, wr_ptr+1.
REQ-007 SHALL accept a read iff rd_en=1 and empty=0: data_out <= mem[rd_ptr] at the same edge, rd_ptr+1, rd_valid=1 for exactly that following cycle.
REQ-008 SHALL give read latency of 1 cycle from an accepted rd_en to valid data_out; no first-word fall-through.
REQ-009 SHALL hold data_out when no read is accepted; rd_valid=0 then.
REQ-010 SHALL use AW-bit pointers that wrap from DEPTH-1 to 0 with no gap or skipped entry.
REQ-011 SHALL update count by +1 (write only), -1 (read only) or 0 (both or neither accepted), using the registered full and empty values of that cycle.
REQ-012 SHALL, when empty, reject rd_en and accept wr_en in the same cycle: count 0->1, rd_valid=0.
REQ-013 SHALL, when full, reject wr_en and accept rd_en in the same cycle: count DEPTH->DEPTH-1, rejected data dropped.
REQ-014 SHALL leave memory, pointers and count unchanged on rejected requests.
REQ-015 SHALL derive full, empty, almost_full and almost_empty combinationally from registered count only; no input-to-flag combinational path.
REQ-016 SHALL set overflow on wr_en=1 with full=1, and set underflow on rd_en=1 with empty=1; both hold until clr_err or rst; a set event in the same cycle as clr_err wins.
REQ-017 SHALL keep count saturated within 0..DEPTH under any input sequence.

Reset
REQ-018 SHALL, on rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0.
REQ-019 SHALL give rst priority over wr_en, rd_en and clr_err; reset mid-operation discards all stored entries.
REQ-020 SHALL not reset the memory array; stale contents are never observable because empty=1 blocks reads.

Structure
REQ-021 SHALL place the log2 helper function and default DATA_W/DEPTH constants in a shared include, hps_fifo_pkg, for reuse by the HPS-memory blocks.
REQ-022 SHALL instantiate one sub-module, hps_fifo_ram: DEPTH x DATA_W, one write port, one registered read port, no reset.
REQ-023 SHALL keep pointer, count, flag and error logic in hps_sync_fifo.

Verification
REQ-024 Reset, then write 0x0001..0x0010 (DEPTH=16): count=16, full=1, almost_full asserted at count 14, overflow=0.
REQ-025 From full, write 0xBEEF: overflow=1, count=16, data unchanged; then read 16 times: data_out 0x0001..0x0010 in order, each 1 cycle after rd_en, empty=1 at end.
REQ-026 From empty, rd_en=1: underflow=1, rd_valid=0; then clr_err=1 with rd_en=1 while empty: underflow stays 1.
REQ-027 Hold count at 8, run wr_en=rd_en=1 for 40 cycles: count stays 8, pointers wrap at least twice, output sequence intact.
REQ-028 Assert rst with count=5 during a simultaneous read/write: next cycle count=0, empty=1, rd_valid=0, data_out=0, flags cleared.

Source files
------------

// File: rtl/hps_fifo_pkg.sv
// Shared constants and helpers for the HPS memory-side blocks.
//   HPS_DATA_W / HPS_DEPTH : default word width and entry count
//   hps_log2()             : ceil(log2(v)), usable in constant expressions
package hps_fifo_pkg;

  localparam int unsigned HPS_DATA_W = 16;
  localparam int unsigned HPS_DEPTH  = 16;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned hps_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hps_fifo_ram.sv
// DEPTH x DATA_W storage: one write port, one registered read port, no reset.
//   clk    : clock, rising edge
//   we     : write enable; wdata stored at waddr
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata loads mem[raddr], otherwise holds
//   raddr  : read address
//   rdata  : registered read data
module hps_fifo_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds when not reading.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hps_sync_fifo.sv
// Single-clock FIFO with registered read data (1-cycle latency, no fall-through),
// occupancy count, full/empty/almost flags and sticky overflow/underflow.
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   wr_en/data_in: write request and data; accepted when not full
//   rd_en        : read request; accepted when not empty
//   data_out     : read data, valid in the cycle rd_valid=1, held otherwise
//   rd_valid     : data_out updated this cycle
//   full/empty/almost_full/almost_empty : decoded from registered count
//   count        : occupancy 0..DEPTH
//   overflow/underflow : sticky error flags, cleared by clr_err or rst
module hps_sync_fifo
  import hps_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = HPS_DATA_W,
  parameter int unsigned DEPTH     = HPS_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned AW       = hps_log2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW-1:0]     wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]     count_d;
  logic              wr_acc, rd_acc;
  logic              dout_live;
  logic [DATA_W-1:0] ram_rdata;

  // Flags depend only on the registered count.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  hps_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset, so data_out reads as zero until the
  // first read after reset has loaded it.
  assign data_out = dout_live ? ram_rdata : '0;

  // Next pointer / count; AW-bit pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = count;
    if (wr_acc) wr_ptr_d = wr_ptr + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Pointer, count and read-valid state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      dout_live <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      count    <= count_d;
      rd_valid <= rd_acc;
      if (rd_acc) dout_live <= 1'b1;
    end
  end

  // Sticky error flags; a new error event beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      else if (clr_err)   overflow  <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

endmodule
